// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman exchange blocks (receive and transmit sides).
package dh_pkg;

    localparam int DH_WIDTH     = 100;
    localparam int DH_EXP_WIDTH = DH_WIDTH + 1;
    localparam int DH_NBYTES    = (DH_WIDTH + 7) / 8;

    typedef enum logic [2:0] {
        S_RECV,
        S_FLUSH,
        S_CHECK,
        S_SQR,
        S_MUL,
        S_DONE
    } dh_state_t;

    // mod_mul handshake: a one-cycle start is sampled only while idle; done pulses
    // mm_latency() cycles later and r stays valid until the next accepted start.
    // A requester that issues start and captures on done spends op_cycles() per product.
    function automatic int mm_latency(input int width);
        return width + 1;
    endfunction

    function automatic int op_cycles(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/dh_peer_rx_mod_mul.sv
// Modular multiplier r = a*b mod p, interleaved shift-add, MSB-first over a.
// Operands must be < p; one iteration per cycle, WIDTH iterations per product.
module mod_mul
    import dh_pkg::*;
#(
    parameter int WIDTH = DH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    localparam int RW = WIDTH + 2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy;
    logic [WIDTH-1:0] a_q;
    logic [RW-1:0]    b_q;
    logic [RW-1:0]    p_q;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    sum;
    logic [RW-1:0]    sub1;
    logic [RW-1:0]    nxt;
    logic [CW-1:0]    cnt;

    // One shift-add step; 2r+b < 3p so two conditional subtractions restore r < p
    always_comb begin
        sum  = (acc << 1) + (a_q[WIDTH-1] ? b_q : '0);
        sub1 = (sum >= p_q) ? sum - p_q : sum;
        nxt  = (sub1 >= p_q) ? sub1 - p_q : sub1;
    end

    // Load on start when idle, then iterate WIDTH times and pulse done on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            p_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    a_q  <= a;
                    b_q  <= RW'(b);
                    p_q  <= RW'(p);
                    acc  <= '0;
                    cnt  <= CW'(WIDTH - 1);
                end
            end else begin
                acc <= nxt;
                a_q <= a_q << 1;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign r = acc[WIDTH-1:0];

endmodule

// File: rtl/dh_peer_rx.sv
// Receives the peer public value Y as an LSB-first byte stream, range-checks it
// against p, and computes Y^priv mod p with a fixed-latency square-and-always-multiply.
module dh_peer_rx
    import dh_pkg::*;
#(
    parameter int WIDTH     = DH_WIDTH,
    parameter int EXP_WIDTH = WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     prime,
    input  logic [EXP_WIDTH-1:0] priv_exp,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_last,
    output logic                 rx_ready,
    output logic [WIDTH-1:0]     secret,
    output logic                 secret_valid,
    input  logic                 secret_ack,
    output logic                 err_invalid,
    output logic                 busy
);

    localparam int NBYTES   = (WIDTH + 7) / 8;
    localparam int YW       = NBYTES * 8;
    localparam int PAD_BITS = YW - WIDTH;
    localparam int BCW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW       = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [7:0]     PAD_MASK  = 8'hFF << (8 - PAD_BITS);

    dh_state_t            state;
    logic [BCW-1:0]       byte_cnt;
    logic [YW-1:0]        y_ext;
    logic [YW-1:0]        prime_ext;
    logic [WIDTH-1:0]     p_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [WIDTH-1:0]     acc;
    logic [IW-1:0]        bit_idx;
    logic                 mm_start;
    logic                 mm_done;
    logic [WIDTH-1:0]     mm_b;
    logic [WIDTH-1:0]     mm_r;
    logic                 xfer;
    logic                 y_ok;

    assign xfer      = rx_valid && rx_ready;
    assign prime_ext = YW'(prime);
    assign y_ok      = (y_ext >= YW'(2)) && (y_ext <= prime_ext - YW'(2));
    assign mm_b      = (state == S_MUL) ? y_ext[WIDTH-1:0] : acc;

    mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (acc),
        .b     (mm_b),
        .p     (p_q),
        .r     (mm_r),
        .done  (mm_done)
    );

    // Frame reception, range check, exponentiation sequencing and result handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RECV;
            byte_cnt     <= '0;
            y_ext        <= '0;
            p_q          <= '0;
            e_q          <= '0;
            acc          <= '0;
            bit_idx      <= '0;
            mm_start     <= 1'b0;
            secret       <= '0;
            secret_valid <= 1'b0;
            err_invalid  <= 1'b0;
            busy         <= 1'b0;
            rx_ready     <= 1'b0;
        end else begin
            mm_start    <= 1'b0;
            err_invalid <= 1'b0;
            unique case (state)
                S_RECV: begin
                    rx_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (xfer) begin
                        y_ext[8*byte_cnt +: 8] <= rx_data;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            if (!rx_last) begin
                                state <= S_FLUSH;
                            end else if ((rx_data & PAD_MASK) != 8'h00) begin
                                err_invalid <= 1'b1;
                            end else begin
                                state    <= S_CHECK;
                                rx_ready <= 1'b0;
                                busy     <= 1'b1;
                            end
                        end else if (rx_last) begin
                            byte_cnt    <= '0;
                            err_invalid <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (xfer && rx_last) begin
                        err_invalid <= 1'b1;
                        state       <= S_RECV;
                    end
                end
                S_CHECK: begin
                    p_q <= prime;
                    e_q <= priv_exp;
                    if (y_ok) begin
                        acc      <= WIDTH'(1);
                        bit_idx  <= IW'(EXP_WIDTH - 1);
                        mm_start <= 1'b1;
                        state    <= S_SQR;
                    end else begin
                        err_invalid <= 1'b1;
                        rx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_RECV;
                    end
                end
                S_SQR: begin
                    if (mm_done) begin
                        acc      <= mm_r;
                        mm_start <= 1'b1;
                        state    <= S_MUL;
                    end
                end
                // Product is always computed; the exponent bit only selects whether it is kept
                S_MUL: begin
                    if (mm_done) begin
                        if (e_q[bit_idx]) begin
                            acc <= mm_r;
                        end
                        if (bit_idx == '0) begin
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            bit_idx  <= bit_idx - 1'b1;
                            mm_start <= 1'b1;
                            state    <= S_SQR;
                        end
                    end
                end
                S_DONE: begin
                    if (!secret_valid) begin
                        secret       <= acc;
                        secret_valid <= 1'b1;
                    end else if (secret_ack) begin
                        secret_valid <= 1'b0;
                        rx_ready     <= 1'b1;
                        state        <= S_RECV;
                    end
                end
                default: begin
                    state <= S_RECV;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dh_peer_rx.sv
// Directed bench for dh_peer_rx at default widths (WIDTH=100, EXP_WIDTH=101).
module tb_dh_peer_rx;

    logic         clk;
    logic         rst;
    logic [99:0]  prime;
    logic [100:0] priv_exp;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_last;
    logic         rx_ready;
    logic [99:0]  secret;
    logic         secret_valid;
    logic         secret_ack;
    logic         err_invalid;
    logic         busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    dh_peer_rx #(.WIDTH(100), .EXP_WIDTH(101)) dut (
        .clk          (clk),
        .rst          (rst),
        .prime        (prime),
        .priv_exp     (priv_exp),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_last      (rx_last),
        .rx_ready     (rx_ready),
        .secret       (secret),
        .secret_valid (secret_valid),
        .secret_ack   (secret_ack),
        .err_invalid  (err_invalid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = last;
        step();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    // Sends n bytes of y LSB-first; rx_last on byte index last_at (-1: never)
    task automatic send_frame(input logic [103:0] y, input int n, input int last_at);
        logic [103:0] yy;
        for (int k = 0; k < n; k++) begin
            yy = y >> (8 * k);
            send_byte(yy[7:0], k == last_at);
        end
    endtask

    // Full exchange; prime/priv_exp are scrambled right after the latch cycle
    task automatic run_exp(input string tag, input logic [99:0] p, input logic [100:0] e,
                           input logic [103:0] y, input logic [99:0] exp_s);
        int unsigned n;
        prime    = p;
        priv_exp = e;
        send_frame(y, 13, 12);
        step();
        prime    = 100'd97;
        priv_exp = '1;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_rdy_busy"}, rx_ready, 1'b0);
        n = 1;
        while (secret_valid !== 1'b1 && n < 21000) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 20606);
        check({tag, "_secret"}, secret, exp_s);
        check({tag, "_busy_done"}, busy, 1'b0);
    endtask

    task automatic ack(input string tag);
        secret_ack = 1'b1;
        step();
        secret_ack = 1'b0;
        check({tag, "_ack_sv"}, secret_valid, 1'b0);
        check({tag, "_ack_rdy"}, rx_ready, 1'b1);
    endtask

    initial begin
        logic [99:0]  p89;
        int unsigned  bad;

        rst        = 1'b1;
        prime      = 100'd23;
        priv_exp   = 101'd6;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        rx_last    = 1'b0;
        secret_ack = 1'b0;
        p89        = (100'd1 << 89) - 100'd1;

        // Reset state
        step();
        step();
        check("rst_rdy", rx_ready, 1'b0);
        check("rst_secret", secret, 100'd0);
        check("rst_sv", secret_valid, 1'b0);
        check("rst_err", err_invalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        check("recv_rdy", rx_ready, 1'b1);

        // Early rx_last on byte 4
        send_frame(104'd19, 5, 4);
        check("short_err", err_invalid, 1'b1);
        check("short_rdy", rx_ready, 1'b1);
        step();
        check("short_err_clr", err_invalid, 1'b0);

        // 15-byte frame: overflow to FLUSH, single error after byte 14
        send_frame(104'd19, 14, -1);
        check("flush_noerr", err_invalid, 1'b0);
        check("flush_rdy", rx_ready, 1'b1);
        send_byte(8'h00, 1'b1);
        check("flush_err", err_invalid, 1'b1);
        step();
        check("flush_err_clr", err_invalid, 1'b0);

        // Pad bit set in final byte (0x10 -> bit 100)
        send_frame(104'h10 << 96, 13, 12);
        check("pad_err", err_invalid, 1'b1);
        step();
        check("pad_err_clr", err_invalid, 1'b0);

        // Out-of-range peer values: 1 and p-1
        send_frame(104'd1, 13, 12);
        check("y1_check_busy", busy, 1'b1);
        check("y1_check_noerr", err_invalid, 1'b0);
        step();
        check("y1_err", err_invalid, 1'b1);
        check("y1_rdy", rx_ready, 1'b1);
        check("y1_sv", secret_valid, 1'b0);
        step();
        check("y1_err_clr", err_invalid, 1'b0);
        send_frame(104'd22, 13, 12);
        step();
        check("y22_err", err_invalid, 1'b1);
        check("y22_rdy", rx_ready, 1'b1);
        check("y22_sv", secret_valid, 1'b0);
        step();

        // 19^6 mod 23 = 2, then hold with ack withheld and traffic offered
        run_exp("p23e6", 100'd23, 101'd6, 104'd19, 100'd2);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        rx_last  = 1'b1;
        bad = 0;
        repeat (50) begin
            step();
            if (secret !== 100'd2 || secret_valid !== 1'b1 || rx_ready !== 1'b0) bad++;
        end
        check("hold_stable", bad, 0);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        ack("p23e6");
        check("p23e6_secret_kept", secret, 100'd2);
        step();
        check("hold_not_consumed", err_invalid, 1'b0);

        // 3^2 mod (2^89-1) = 9
        run_exp("p89", p89, 101'd2, 104'd3, 100'd9);
        ack("p89");

        // Reset mid-exponentiation, then a fresh exchange with priv=0
        prime    = 100'd23;
        priv_exp = 101'd15;
        send_frame(104'd8, 13, 12);
        repeat (5000) step();
        check("abort_busy_pre", busy, 1'b1);
        rst = 1'b1;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_sv", secret_valid, 1'b0);
        check("abort_secret", secret, 100'd0);
        rst = 1'b0;
        step();
        check("abort_rdy", rx_ready, 1'b1);
        run_exp("p23e0", 100'd23, 101'd0, 104'd5, 100'd1);
        ack("p23e0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dh_peer_rx.md
Name: dh_peer_rx

Overview:
- Receiving end of the Diffie-Hellman public-value exchange.
- Accepts the peer's public value Y as a byte stream over a valid/ready link and range-checks it against the prime.
- Computes the shared secret Y^priv mod p with a constant-time square-and-always-multiply engine.
- Sits between the link interface and key derivation; the local public value is produced elsewhere.

Parameters:
- WIDTH, 100, bit width of prime, peer value and secret.
- EXP_WIDTH, WIDTH+1, bit width of private exponent.
- NBYTES, ceil(WIDTH/8) (=13), derived localparam: bytes per public value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- prime  in  WIDTH  modulus p. Must be odd, 5 <= p < 2^WIDTH. Latched at CHECK.
- priv_exp  in  EXP_WIDTH  private exponent. Latched at CHECK.
- rx_data  in  8  peer value byte, LSB-first.
- rx_valid  in  1  byte valid.
- rx_last  in  1  final byte of frame, qualified by rx_valid.
- rx_ready  out  1  block accepts a byte.
- secret  out  WIDTH  shared secret.
- secret_valid  out  1  secret is valid; held until acked.
- secret_ack  in  1  consumer takes secret.
- err_invalid  out  1  one-cycle pulse: frame or value rejected.
- busy  out  1  high in CHECK/EXP states.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst). Reset aborts any operation, including mid-exponentiation, and returns to RECV.
- Reset values: rx_ready=0 in the reset cycle and 1 from the next cycle (RECV); secret=0, secret_valid=0, err_invalid=0, busy=0; byte count=0.
- A byte transfers on any cycle where rx_valid and rx_ready are both high.
- RECV (rx_ready=1): byte k is written to Y[8k+7:8k]. Bits at and above WIDTH in the final byte must be 0.
  - rx_last on byte NBYTES-1 with the pad bits zero -> CHECK.
  - rx_last before byte NBYTES-1, or nonzero pad bits on the last byte -> pulse err_invalid, clear count, stay in RECV.
  - Byte NBYTES-1 without rx_last -> FLUSH.
- FLUSH (rx_ready=1): discard bytes until a byte with rx_last transfers, then pulse err_invalid the next cycle and go to RECV.
- CHECK (1 cycle): latch prime and priv_exp.
  - Require 2 <= Y <= p-2; otherwise pulse err_invalid and go to RECV.
  - If valid: acc=1, bit index i=EXP_WIDTH-1 -> SQR.
- SQR: acc := acc*acc mod p, via mod_mul -> MUL.
- MUL: t := acc*Y mod p, always computed. acc := priv_exp[i] ? t : acc.
  - If i==0 -> DONE; else decrement i -> SQR.
- Each SQR/MUL occupies exactly WIDTH+2 cycles: 1 start, WIDTH iterations, 1 capture.
- Fixed latency, independent of data: secret_valid rises 2 + 2*EXP_WIDTH*(WIDTH+2) cycles after the last-byte transfer (20606 at defaults).
- DONE: secret=acc, secret_valid=1, rx_ready=0. secret_ack while valid -> secret_valid=0 next cycle, go to RECV. secret is held until the next DONE or reset.
- priv_exp=0 yields secret=1.
- Changes to prime or priv_exp after CHECK have no effect.
- rx_ready=0 in CHECK/SQR/MUL/DONE; input bytes are not consumed there.
- mod_mul arithmetic: interleaved shift-add, MSB-first over operand a.
  - Each iteration: r := 2r + (a_j ? b : 0), then up to two conditional subtractions of p.
  - Internal width WIDTH+2; operands and result are always < p.

Decomposition:
- Shared package dh_pkg: WIDTH, EXP_WIDTH, NBYTES; the state enum (RECV, FLUSH, CHECK, SQR, MUL, DONE); and the mod_mul start/done protocol.
- The same package is reused by the exponentiation/transmit side.
- One sub-module, mod_mul:
  - Inputs: clk, rst, start, a, b, p.
  - Outputs: r, done.
  - done is a one-cycle pulse WIDTH+1 cycles after start.
  - Ignores start while busy.

Test Plan:
- p=23, priv=6, peer bytes {19,0,...,0} with rx_last on byte 12 -> secret=2; secret_valid asserted at exactly cycle +20606; cleared by secret_ack.
- p=23, priv=15, peer=8 -> secret=2. Then p=23, priv=0, peer=5 -> secret=1.
- p=2^89-1, priv=2, peer=3 -> secret=9. Peer=1, and separately peer=22 with p=23 -> err_invalid pulse, no secret_valid, rx_ready=1 next cycle.
- Framing errors:
  - rx_last on byte 4 -> err_invalid.
  - 15 bytes with rx_last on byte 14 -> FLUSH, then one err_invalid after byte 14.
  - Final byte 0x10 (pad bit set) -> err_invalid.
- rst asserted at cycle 5000 of an exponentiation -> next cycle: busy=0, secret_valid=0. A fresh frame then yields the correct secret.
- secret_ack withheld for 50 cycles -> secret stable, rx_ready=0, incoming rx_valid not consumed.
